// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with hold limit and registered outputs
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, ptr_nx, id_nx;
  logic [4:0] hold_cnt, hold_nx;
  logic [7:0] others;
  logic [3:0] cand;
  logic at_max;
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] j;
    pick = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      j = p + 3'(i);
      if (r[j]) pick = {1'b1, j};
    end
  endfunction
  // next-state: first requester in search order from ptr; the holder is excluded when it releases or is rotated out
  always_comb begin
    others   = req & ~(8'd1 << gnt_id);
    cand     = pick(state == IDLE ? req : others, ptr);
    at_max   = hold_cnt == 5'(HOLD_MAX - 1);
    state_nx = state;
    ptr_nx   = ptr;
    id_nx    = gnt_id;
    hold_nx  = hold_cnt;
    if (state == GRANT && req[gnt_id] && !at_max) begin
      hold_nx = hold_cnt + 5'd1;
    end else if (cand[3]) begin
      state_nx = GRANT;
      id_nx    = cand[2:0];
      ptr_nx   = cand[2:0] + 3'd1;
      hold_nx  = 5'd0;
    end else if (state == GRANT && req[gnt_id]) begin
      hold_nx = 5'd0;
    end else begin
      state_nx = IDLE;
      id_nx    = 3'd0;
      hold_nx  = 5'd0;
    end
  end
  // state, pointer, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 5'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt       <= state_nx == GRANT ? 8'd1 << id_nx : 8'h00;
      gnt_id    <= id_nx;
      gnt_valid <= state_nx == GRANT;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed checks of rr_arbiter_8 at HOLD_MAX 8, 4, 2 and 1
module tb_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt8, gnt4, gnt2, gnt1;
  logic [2:0] id8, id4, id2, id1;
  logic v8, v4, v2, v1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rr_arbiter_8 u8 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8));
  rr_arbiter_8 #(.HOLD_MAX(4)) u4 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4));
  rr_arbiter_8 #(.HOLD_MAX(2)) u2 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt2), .gnt_id(id2), .gnt_valid(v2));
  rr_arbiter_8 #(.HOLD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [2:0] e;
    do_reset();
    check("rst_gnt", gnt8, 8'h00);
    check("rst_id", id8, 3'd0);
    check("rst_valid", v8, 1'b0);
    check("rst_gnt2", gnt2, 8'h00);
    req = 8'h20;
    step();
    check("single_gnt", gnt8, 8'h20);
    check("single_id", id8, 3'd5);
    check("single_valid", v8, 1'b1);
    req = 8'h00;
    step();
    check("single_drop_gnt", gnt8, 8'h00);
    check("single_drop_valid", v8, 1'b0);
    step();
    check("idle_stays", gnt8, 8'h00);
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 17; c++) begin
      step();
      e = 3'((c / 2) % 8);
      check($sformatf("rr_id%0d", c), id2, e);
      check($sformatf("rr_gnt%0d", c), gnt2, 8'd1 << e);
    end
    do_reset();
    req = 8'h08;
    step();
    check("b2b_hold3", gnt8, 8'h08);
    req = 8'h48;
    step();
    check("b2b_still3", gnt8, 8'h08);
    req = 8'h40;
    step();
    check("b2b_gnt6", gnt8, 8'h40);
    check("b2b_valid", v8, 1'b1);
    req = 8'h80;
    step();
    check("wrap_gnt7", gnt8, 8'h80);
    req = 8'h03;
    step();
    check("wrap_gnt0", gnt8, 8'h01);
    check("wrap_id0", id8, 3'd0);
    req = 8'h02;
    step();
    check("wrap_gnt1", gnt8, 8'h02);
    do_reset();
    req = 8'h04;
    step();
    check("force_start", gnt4, 8'h04);
    check("h1_start", gnt1, 8'h04);
    req = 8'h24;
    step();
    check("h1_rotate", gnt1, 8'h20);
    check("force_keep1", gnt4, 8'h04);
    step();
    check("force_keep2", gnt4, 8'h04);
    step();
    check("force_keep3", gnt4, 8'h04);
    step();
    check("force_move5", gnt4, 8'h20);
    check("force_id5", id4, 3'd5);
    req = 8'h20;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("lone_keep%0d", c), gnt4, 8'h20);
    end
    do_reset();
    req = 8'h10;
    step();
    check("mid_gnt4", gnt8, 8'h10);
    rst_n = 1'b0;
    step();
    check("mid_rst_gnt", gnt8, 8'h00);
    check("mid_rst_id", id8, 3'd0);
    check("mid_rst_valid", v8, 1'b0);
    rst_n = 1'b1;
    req = 8'h11;
    step();
    check("post_rst_gnt0", gnt8, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
